exp6_condicionador_botoes: RTL



---
 rtl/exp6_pkg.sv | 21 ++
 rtl/exp6_sincronizador.sv | 26 ++
 rtl/exp6_condicionador_botoes.sv | 137 +++++++++++++
 3 files changed

// File: rtl/exp6_pkg.sv
// Shared definitions for the exp6 button conditioning path: FSM state
// encodings, default sizing and a one-hot helper.
package exp6_pkg;

    typedef enum logic [1:0] {
        OCIOSO      = 2'b00,
        FILTRANDO   = 2'b01,
        PRESSIONADO = 2'b10,
        SOLTANDO    = 2'b11
    } estado_t;

    // 1 ms of stable input at 50 MHz
    localparam int DEBOUNCE_CICLOS_PADRAO = 50000;
    localparam int N_BOTOES_PADRAO        = 4;

    // True when exactly one bit is set; callers zero-extend narrower vectors
    function automatic logic eh_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/exp6_sincronizador.sv
// Two-flop synchronizer for a vector of asynchronous levels. Each bit is
// synchronized independently; multi-bit coherence is restored downstream by
// the debounce filter, which requires the whole vector to be stable.
module exp6_sincronizador #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture; q is d delayed by two rising edges
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exp6_condicionador_botoes.sv
// Button conditioning ahead of exp6_fluxo_dados: synchronize, debounce,
// hold a stable copy of the buttons and emit one-cycle play pulses.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   OCIOSO      | no button seen; waiting for a nonzero synchronized value
//   FILTRANDO   | candidate value in amostra; counting stable samples
//   PRESSIONADO | press accepted and latched on botoes; waiting for release
//   SOLTANDO    | all released; counting stable zero samples before clearing
module exp6_condicionador_botoes
    import exp6_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_BOTOES-1:0] botoes_raw,
    input  logic                habilita,
    output logic [N_BOTOES-1:0] botoes,
    output logic                jogada_feita,
    output logic                jogada_invalida,
    output logic                db_tem_jogada,
    output logic [1:0]          db_estado
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0]  CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] sync;
    logic [N_BOTOES-1:0] amostra, amostra_prox;
    logic [N_BOTOES-1:0] botoes_prox;
    logic [CNT_W-1:0]    cnt, cnt_prox;
    logic                feita_prox, invalida_prox;
    logic                amostra_one_hot;
    estado_t             estado, estado_prox;

    exp6_sincronizador #(
        .W (N_BOTOES)
    ) u_sincronizador (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (botoes_raw),
        .q       (sync)
    );

    assign amostra_one_hot = eh_one_hot(32'(amostra));

    // State, counter, sample and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado          <= OCIOSO;
            cnt             <= '0;
            amostra         <= '0;
            botoes          <= '0;
            jogada_feita    <= 1'b0;
            jogada_invalida <= 1'b0;
        end else begin
            estado          <= estado_prox;
            cnt             <= cnt_prox;
            amostra         <= amostra_prox;
            botoes          <= botoes_prox;
            jogada_feita    <= feita_prox;
            jogada_invalida <= invalida_prox;
        end
    end

    // Next-state, counter and pulse decisions. Pulses are only produced on
    // the FILTRANDO->PRESSIONADO transition, so they can never repeat on
    // consecutive cycles, and a press accepted with habilita low is consumed.
    always_comb begin
        estado_prox   = estado;
        cnt_prox      = cnt;
        amostra_prox  = amostra;
        botoes_prox   = botoes;
        feita_prox    = 1'b0;
        invalida_prox = 1'b0;

        case (estado)
            OCIOSO: begin
                if (sync != '0) begin
                    amostra_prox = sync;
                    cnt_prox     = '0;
                    estado_prox  = FILTRANDO;
                end
            end

            FILTRANDO: begin
                if (sync == '0) begin
                    estado_prox = OCIOSO;
                end else if (sync != amostra) begin
                    amostra_prox = sync;
                    cnt_prox     = '0;
                end else if (cnt == CNT_FIM) begin
                    estado_prox = PRESSIONADO;
                    botoes_prox = amostra;
                    if (habilita) begin
                        if (amostra_one_hot) begin
                            feita_prox = 1'b1;
                        end else begin
                            invalida_prox = 1'b1;
                        end
                    end
                end else begin
                    cnt_prox = cnt + CNT_W'(1);
                end
            end

            PRESSIONADO: begin
                // A different nonzero value is ignored until a release
                if (sync == '0) begin
                    cnt_prox    = '0;
                    estado_prox = SOLTANDO;
                end
            end

            SOLTANDO: begin
                if (sync != '0) begin
                    estado_prox = PRESSIONADO;
                end else if (cnt == CNT_FIM) begin
                    botoes_prox = '0;
                    estado_prox = OCIOSO;
                end else begin
                    cnt_prox = cnt + CNT_W'(1);
                end
            end

            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    assign db_tem_jogada = (botoes != '0);
    assign db_estado     = estado;

endmodule
